// File: rtl/spi_link_pkg.sv
// spi_link_pkg
//   Shared constants and types for the SPI register-write link.
//   Frame layout (MSB first): {write flag, address[6:0], data[7:0]}.
package spi_link_pkg;

  localparam int FRAME_W     = 16;
  localparam int WR_FLAG_BIT = 15;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int CMD_W       = ADDR_W + DATA_W;

  // This link only ever writes registers, so the flag is always 0.
  localparam logic WR_FLAG = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } spi_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a registered, prefetched output word.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     wr_en       write request (ignored while !ready)
//     wr_data     write word
//     rd_en       pop the word on rd_data (ignored while !rd_valid)
//     rd_data     head word, registered
//     rd_valid    rd_data holds a valid entry
//     level       occupied entries including the output register
//     level_next  value level takes on the next edge
//     ready       registered !full
module sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [$clog2(DEPTH+1)-1:0]   level_next,
  output logic                         ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    mem_cnt;
  logic [LW-1:0]    mem_cnt_next;
  logic             push;
  logic             pop;
  logic             load;

  // The output register refills from memory whenever it is empty or being
  // popped, so a freshly written word reaches rd_data one edge after the
  // write. level counts memory plus output register.
  always_comb begin
    push = wr_en && ready;
    pop  = rd_en && rd_valid;
    load = (mem_cnt != '0) && (!rd_valid || pop);

    level_next = level;
    if (push && !pop)
      level_next = level + 1'b1;
    else if (!push && pop)
      level_next = level - 1'b1;

    mem_cnt_next = mem_cnt;
    if (push && !load)
      mem_cnt_next = mem_cnt + 1'b1;
    else if (!push && load)
      mem_cnt_next = mem_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
      ready    <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt_next;
      level   <= level_next;
      ready   <= (level_next != LW'(DEPTH));
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx
//   SPI mode-0 master that serialises buffered register-write commands as
//   16-bit CS-framed transfers, MSB first.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     cmd_valid    command offered;   cmd_ready  FIFO not full
//     cmd_addr     7-bit register address
//     cmd_data     8-bit register data
//     spi_mosi     serial data;  spi_sck  serial clock (idle low)
//     spi_cs       chip select, active low
//     busy         frame in progress or FIFO non-empty
//     done         one-cycle pulse as CS rises at the end of a frame
//     fifo_level   occupied FIFO entries
//
//   state    | meaning
//   IDLE     | CS high, pop a command when one is available
//   SETUP    | CS low, SCK low, CS_SETUP cycles before the first rise
//   SHIFT_HI | SCK high for CLK_DIV cycles, MOSI stable
//   SHIFT_LO | SCK low for CLK_DIV cycles, MOSI moved to the next bit
//   HOLD     | SCK low, last bit held for CS_HOLD cycles
//   GAP      | CS high, MOSI low for CS_GAP cycles
module spi_master_tx
  import spi_link_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [ADDR_W-1:0]                 cmd_addr,
  input  logic [DATA_W-1:0]                 cmd_data,
  output logic                              spi_mosi,
  output logic                              spi_sck,
  output logic                              spi_cs,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("spi_master_tx: CLK_DIV must be at least 4");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 1) begin : g_bad_cs_timing
    $error("spi_master_tx: CS_SETUP, CS_HOLD and CS_GAP must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_master_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end

  localparam int LW   = $clog2(FIFO_DEPTH+1);
  localparam int PMAX = max_int(max_int(CLK_DIV, CS_SETUP), max_int(CS_HOLD, CS_GAP));
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] DIV_LD   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LD = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LD  = PW'(CS_HOLD - 1);
  localparam logic [PW-1:0] GAP_LD   = PW'(CS_GAP - 1);

  spi_state_t         state;
  logic [PW-1:0]      phase;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] shreg;

  logic [CMD_W-1:0]   fifo_data;
  logic               fifo_valid;
  logic               fifo_pop;
  logic [LW-1:0]      level_next;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (cmd_valid),
    .wr_data    ({cmd_addr, cmd_data}),
    .rd_en      (fifo_pop),
    .rd_data    (fifo_data),
    .rd_valid   (fifo_valid),
    .level      (fifo_level),
    .level_next (level_next),
    .ready      (cmd_ready)
  );

  assign fifo_pop = (state == IDLE) && fifo_valid;

  // MOSI is the top bit of the shift register flop; clearing the register
  // at the end of HOLD gives MOSI=0 through GAP.
  assign spi_mosi = shreg[WR_FLAG_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      spi_cs  <= 1'b1;
      spi_sck <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_valid) begin
            shreg   <= {WR_FLAG, fifo_data};
            spi_cs  <= 1'b0;
            bit_cnt <= 4'd15;
            phase   <= SETUP_LD;
            busy    <= 1'b1;
            state   <= SETUP;
          end else begin
            busy <= (level_next != '0);
          end
        end
        SETUP: begin
          if (phase == '0) begin
            spi_sck <= 1'b1;
            phase   <= DIV_LD;
            state   <= SHIFT_HI;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        SHIFT_HI: begin
          if (phase == '0) begin
            spi_sck <= 1'b0;
            phase   <= DIV_LD;
            state   <= SHIFT_LO;
            // Present the next bit on the same edge SCK falls; the last bit
            // stays on MOSI through HOLD.
            if (bit_cnt != 4'd0)
              shreg <= {shreg[FRAME_W-2:0], 1'b0};
          end else begin
            phase <= phase - 1'b1;
          end
        end
        SHIFT_LO: begin
          if (phase == '0) begin
            if (bit_cnt == 4'd0) begin
              phase <= HOLD_LD;
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
              spi_sck <= 1'b1;
              phase   <= DIV_LD;
              state   <= SHIFT_HI;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        HOLD: begin
          if (phase == '0) begin
            spi_cs <= 1'b1;
            shreg  <= '0;
            done   <= 1'b1;
            phase  <= GAP_LD;
            state  <= GAP;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        GAP: begin
          if (phase == '0) begin
            busy  <= (level_next != '0);
            state <= IDLE;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_valid2;
  logic [6:0] cmd_addr, cmd_addr2;
  logic [7:0] cmd_data, cmd_data2;
  logic       cmd_ready, spi_mosi, spi_sck, spi_cs, busy, done;
  logic [2:0] fifo_level;
  logic       cmd_ready2, spi_mosi2, spi_sck2, spi_cs2, busy2, done2;
  logic [2:0] fifo_level2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_tx dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .spi_mosi(spi_mosi),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .busy(busy), .done(done),
    .fifo_level(fifo_level)
  );

  spi_master_tx #(.CLK_DIV(8), .CS_SETUP(3), .CS_HOLD(3)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .spi_mosi(spi_mosi2),
    .spi_sck(spi_sck2), .spi_cs(spi_cs2), .busy(busy2), .done(done2),
    .fifo_level(fifo_level2)
  );

  // ---------------- monitor for dut (default timing) ----------------
  logic        a_prev_cs = 1'b1, a_prev_sck = 1'b0;
  logic [15:0] a_word = '0;
  int          a_rises = 0, a_low = 0, a_gap = 0, a_post_busy = 0;
  int          a_done_cnt = 0, a_fr_n = 0, a_gap_n = 0;
  logic [15:0] a_fr_word [64];
  int          a_fr_rises [64];
  int          a_fr_low [64];
  logic        a_fr_done [64];
  int          a_gap_v [64];

  always @(negedge clk) begin
    a_prev_cs  <= spi_cs;
    a_prev_sck <= spi_sck;
    if (done === 1'b1) a_done_cnt <= a_done_cnt + 1;
    if (a_prev_cs && spi_cs === 1'b0) begin
      a_low   <= 1;
      a_rises <= 0;
      a_word  <= '0;
      if (a_gap_n < 64) a_gap_v[a_gap_n] <= a_gap;
      a_gap_n <= a_gap_n + 1;
    end else if (spi_cs === 1'b0) begin
      a_low <= a_low + 1;
      if (spi_sck && !a_prev_sck) begin
        a_word  <= {a_word[14:0], spi_mosi};
        a_rises <= a_rises + 1;
      end
    end else if (!a_prev_cs) begin
      if (a_fr_n < 64) begin
        a_fr_word[a_fr_n]  <= a_word;
        a_fr_rises[a_fr_n] <= a_rises;
        a_fr_low[a_fr_n]   <= a_low;
        a_fr_done[a_fr_n]  <= done;
      end
      a_fr_n      <= a_fr_n + 1;
      a_gap       <= 1;
      a_post_busy <= busy ? 1 : 0;
    end else begin
      a_gap <= a_gap + 1;
      if (busy === 1'b1) a_post_busy <= a_post_busy + 1;
    end
  end

  // ---------------- monitor for dut2 (slow timing) ----------------
  logic        b_prev_cs = 1'b1, b_prev_sck = 1'b0;
  logic [15:0] b_word = '0, b_last_word = '0;
  int          b_rises = 0, b_low = 0, b_hi_run = 0, b_lo_run = 0;
  int          b_hi_min = 999, b_hi_max = 0, b_lo_min = 999, b_lo_max = 0;
  int          b_last_rises = 0, b_last_low = 0, b_fr_n = 0;

  always @(negedge clk) begin
    b_prev_cs  <= spi_cs2;
    b_prev_sck <= spi_sck2;
    if (b_prev_cs && spi_cs2 === 1'b0) begin
      b_low <= 1; b_rises <= 0; b_word <= '0;
      b_hi_min <= 999; b_hi_max <= 0; b_lo_min <= 999; b_lo_max <= 0;
      b_hi_run <= 0; b_lo_run <= 1;
    end else if (spi_cs2 === 1'b0) begin
      b_low <= b_low + 1;
      if (spi_sck2 && !b_prev_sck) begin
        b_word   <= {b_word[14:0], spi_mosi2};
        b_rises  <= b_rises + 1;
        b_hi_run <= 1;
        if (b_rises > 0) begin
          b_lo_min <= (b_lo_run < b_lo_min) ? b_lo_run : b_lo_min;
          b_lo_max <= (b_lo_run > b_lo_max) ? b_lo_run : b_lo_max;
        end
      end else if (spi_sck2) begin
        b_hi_run <= b_hi_run + 1;
      end else if (b_prev_sck) begin
        b_hi_min <= (b_hi_run < b_hi_min) ? b_hi_run : b_hi_min;
        b_hi_max <= (b_hi_run > b_hi_max) ? b_hi_run : b_hi_max;
        b_lo_run <= 1;
      end else begin
        b_lo_run <= b_lo_run + 1;
      end
    end else if (!b_prev_cs) begin
      b_last_word  <= b_word;
      b_last_rises <= b_rises;
      b_last_low   <= b_low;
      b_fr_n       <= b_fr_n + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_a_frames(input int n);
    int k = 0;
    while (a_fr_n < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    tick(1);
    check("frame_wait_timeout", (a_fr_n >= n), 1);
  endtask

  task automatic check_a_frame(input string tag, input int idx, input logic [15:0] word);
    check({tag, "_word"},  a_fr_word[idx], word);
    check({tag, "_rises"}, a_fr_rises[idx], 16);
    check({tag, "_cslow"}, a_fr_low[idx], 132);
    check({tag, "_done"},  a_fr_done[idx], 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, g0, d0, k, sent;
    logic saw_not_ready;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_valid2 = 1'b0; cmd_addr2 = '0; cmd_data2 = '0;
    tick(3);

    // reset state
    check("rst_cs", spi_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    tick(2);

    // single write 0x01/0x5A with push-to-CS latency
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 7'h01; cmd_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("lat_busy_after_push", busy, 1);
    check("lat_cs_n0", spi_cs, 1);
    @(negedge clk);
    check("lat_cs_n1", spi_cs, 1);
    @(negedge clk);
    check("lat_cs_n2", spi_cs, 0);
    wait_a_frames(1);
    check_a_frame("single", 0, 16'h015A);
    check("single_done_count", a_done_cnt, 1);
    tick(10);
    check("idle_sck", spi_sck, 0);
    check("idle_mosi", spi_mosi, 0);
    check("idle_busy", busy, 0);

    // data patterns
    push_a(7'h7F, 8'hFF);
    wait_a_frames(2);
    check_a_frame("ones", 1, 16'h7FFF);
    tick(10);
    push_a(7'h00, 8'h00);
    wait_a_frames(3);
    check_a_frame("zeros", 2, 16'h0000);
    tick(10);

    // streaming 8 commands with cmd_valid held
    base = a_fr_n;
    g0 = a_gap_n;
    sent = 0; k = 0; saw_not_ready = 1'b0;
    while (sent < 8 && k < 2000) begin
      @(negedge clk);
      k++;
      check("stream_ready_vs_level", cmd_ready, (fifo_level != 3'd4));
      if (!cmd_ready) saw_not_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_addr  = 7'(sent);
      cmd_data  = 8'h10 + 8'(sent);
      if (cmd_ready) sent++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("stream_all_sent", sent, 8);
    check("stream_ready_dropped", saw_not_ready, 1);
    wait_a_frames(base + 8);
    for (int i = 0; i < 8; i++)
      check_a_frame("stream", base + i, {1'b0, 7'(i), 8'h10 + 8'(i)});
    for (int i = 1; i < 8; i++)
      check("stream_cs_gap", a_gap_v[g0 + i], 5);
    tick(20);
    check("stream_busy_after_last", a_post_busy, 4);
    check("stream_busy_final", busy, 0);

    // reset at the 7th SCK rise of a frame, second command queued
    base = a_fr_n;
    push_a(7'h22, 8'h33);
    push_a(7'h44, 8'h55);
    k = 0;
    while (!(spi_cs === 1'b0 && a_rises == 7) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("midrst_reached_rise7", a_rises, 7);
    d0 = a_done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs", spi_cs, 1);
    check("midrst_sck", spi_sck, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    tick(20);
    check("midrst_no_done_pulse", a_done_cnt, d0);
    check("midrst_abandoned_frame", a_fr_n, base + 1);
    push_a(7'h05, 8'hA5);
    wait_a_frames(base + 2);
    check_a_frame("after_rst", base + 1, 16'h05A5);
    tick(200);
    check("midrst_queued_cmd_dropped", a_fr_n, base + 2);

    // slow instance: CLK_DIV=8, CS_SETUP=3, CS_HOLD=3
    @(negedge clk);
    cmd_valid2 = 1'b1; cmd_addr2 = 7'h2A; cmd_data2 = 8'h3C;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    k = 0;
    while (b_fr_n < 1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    tick(1);
    check("slow_frame_seen", b_fr_n, 1);
    check("slow_word", b_last_word, 16'h2A3C);
    check("slow_rises", b_last_rises, 16);
    check("slow_cslow", b_last_low, 262);
    check("slow_sck_hi_min", b_hi_min, 8);
    check("slow_sck_hi_max", b_hi_max, 8);
    check("slow_sck_lo_min", b_lo_min, 8);
    check("slow_sck_lo_max", b_lo_max, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
